// File: rtl/psum_drain.sv
// psum_drain: accumulates PE-column partial sums over several passes and requantizes the final
// pass into a 2-entry output FIFO. Optional macro PSUM_DRAIN_RELU_EN zeroes negative sums first.
module psum_drain #(
    parameter int accumulationPar = 32,
    parameter int outPar          = 8,
    parameter int DEPTH           = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic [7:0]                 cfg_passes,
    input  logic [4:0]                 cfg_shift,
    input  logic [accumulationPar-1:0] psum_in,
    input  logic                       psum_valid,
    output logic                       psum_ready,
    output logic [outPar-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic signed [accumulationPar-1:0] SAT_MAX =
        {{(accumulationPar-outPar+1){1'b0}}, {(outPar-1){1'b1}}};
    localparam logic signed [accumulationPar-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [LW-1:0]                len_q, len_d;
    logic [7:0]                   passes_q, passes_d;
    logic [7:0]                   pc_q, pc_d;
    logic [4:0]                   shift_q, shift_d;
    logic [PW-1:0]                ptr_q, ptr_d;
    logic [1:0]                   count_q, count_d;
    logic                         wr_ptr_q, rd_ptr_q;
    logic [outPar-1:0]            fifo_data_q [2];
    logic [1:0]                   fifo_last_q;
    logic [accumulationPar-1:0]   acc_mem [DEPTH];

    logic                         accept, push, pop, last_pass, last_entry;
    logic signed [accumulationPar-1:0] sum, relu_sum, shifted;
    logic [outPar-1:0]            quant;

    // Ready depends only on registered state so out_ready never reaches psum_ready.
    assign psum_ready = (state_q == RUN) && (count_q != 2'd2);
    assign accept     = psum_valid && psum_ready;
    assign last_pass  = (pc_q == passes_q - 8'd1);
    assign last_entry = ({1'b0, ptr_q} == (len_q - LW'(1)));
    assign push       = accept && last_pass;
    assign pop        = out_valid && out_ready;

    assign sum = (pc_q == 8'd0) ? psum_in : acc_mem[ptr_q] + psum_in;
`ifdef PSUM_DRAIN_RELU_EN
    assign relu_sum = sum[accumulationPar-1] ? '0 : sum;
`else
    assign relu_sum = sum;
`endif
    assign shifted = relu_sum >>> shift_q;

    always_comb begin
        quant = shifted[outPar-1:0];
        if (shifted > SAT_MAX) begin
            quant = SAT_MAX[outPar-1:0];
        end else if (shifted < SAT_MIN) begin
            quant = SAT_MIN[outPar-1:0];
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = fifo_last_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN) && (count_q == 2'd0);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        passes_d = passes_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        pc_d     = pc_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    ptr_d    = '0;
                    pc_d     = '0;
                    shift_d  = cfg_shift;
                    passes_d = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                    if (cfg_len == '0) begin
                        len_d = LW'(1);
                    end else if (cfg_len > LW'(DEPTH)) begin
                        len_d = LW'(DEPTH);
                    end else begin
                        len_d = cfg_len;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_entry) begin
                        ptr_d = '0;
                        if (last_pass) begin
                            state_d = DRAIN;
                            pc_d    = '0;
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            len_q          <= LW'(1);
            passes_q       <= 8'd1;
            shift_q        <= '0;
            ptr_q          <= '0;
            pc_q           <= '0;
            count_q        <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            passes_q <= passes_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= quant;
                fifo_last_q[wr_ptr_q] <= last_entry;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Accumulator contents are only meaningful after a first-pass write, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_mem[ptr_q] <= sum;
        end
    end
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: scenario tasks driving psum_drain, checked against a queue-based pass model.
// Honours PSUM_DRAIN_RELU_EN the same way the design does.
module tb_psum_drain;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4:0]        cfg_len;
    logic [7:0]        cfg_passes;
    logic [4:0]        cfg_shift;
    logic [31:0]       psum_in;
    logic              psum_valid;
    logic              psum_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    logic signed [31:0] beats[$];
    logic [7:0]         got_data[$];
    logic               got_last[$];
    logic [7:0]         exp_data[$];
    logic               exp_last[$];
    int                 done_cyc, last_pop_cyc, n_done;
    bit                 timed_out;
    int                 checks = 0;
    int                 errors = 0;

    psum_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_passes (cfg_passes),
        .cfg_shift  (cfg_shift),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] rand_psum();
        int v;
        case ($urandom_range(2))
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(1000)) - 500;
            default: v = int'($urandom_range(100000)) - 50000;
        endcase
        return v;
    endfunction

    // Reference: per-entry running totals across passes, final pass requantized.
    task automatic build_expected(input int len, input int passes, input int shift);
        logic signed [31:0] acc [16];
        logic signed [31:0] s, sh;
        logic [7:0]         q;
        exp_data.delete();
        exp_last.delete();
        for (int p = 0; p < passes; p++) begin
            for (int e = 0; e < len; e++) begin
                s = (p == 0) ? beats[p*len+e] : acc[e] + beats[p*len+e];
                acc[e] = s;
                if (p == passes - 1) begin
`ifdef PSUM_DRAIN_RELU_EN
                    if (s < 0) s = 0;
`endif
                    sh = s >>> shift;
                    if (sh > 127)       q = 8'h7F;
                    else if (sh < -128) q = 8'h80;
                    else                q = sh[7:0];
                    exp_data.push_back(q);
                    exp_last.push_back(e == len - 1);
                end
            end
        end
    endtask

    task automatic do_start(input int len, input int passes, input int shift);
        @(negedge clk);
        cfg_len    = len[4:0];
        cfg_passes = passes[7:0];
        cfg_shift  = shift[4:0];
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Feeds the beats queue and collects popped outputs; decisions are made at negedge.
    task automatic run_job(input int valid_pct, input int ready_pct, input bit stop_when_fed,
                           input int max_cycles);
        int bi  = 0;
        int cyc = 0;
        bit fin = 0;
        got_data.delete();
        got_last.delete();
        n_done = 0; done_cyc = -1; last_pop_cyc = -1; timed_out = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                n_done++; done_cyc = cyc; fin = 1;
            end else if (stop_when_fed && bi == beats.size()) begin
                fin = 1;
            end else if (cyc > max_cycles) begin
                timed_out = 1; fin = 1;
            end else begin
                psum_valid = (bi < beats.size()) && ($urandom_range(99) < valid_pct);
                psum_in    = (bi < beats.size()) ? beats[bi] : $urandom;
                out_ready  = ($urandom_range(99) < ready_pct);
                if (psum_valid && psum_ready) bi++;
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    last_pop_cyc = cyc;
                end
            end
        end
        psum_valid = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({psum_ready, out_valid, out_data, out_last, busy, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold: outs=%b required all zero",
                     {psum_ready, out_valid, out_data, out_last, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({psum_ready, out_valid, out_data, out_last, busy, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_release: outs=%b required all zero",
                     {psum_ready, out_valid, out_data, out_last, busy, done});
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] req [4];
`ifdef PSUM_DRAIN_RELU_EN
        req = '{8'd5, 8'd0, 8'd127, 8'd0};
`else
        req = '{8'd5, 8'hFD, 8'd127, 8'h80};
`endif
        beats = '{32'sd5, -32'sd3, 32'sd200, -32'sd200};
        do_start(4, 1, 0);
        checks++;
        if (busy !== 1'b1 || psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: busy=%b psum_ready=%b required 1 1", busy, psum_ready);
        end
        run_job(100, 100, 0, 200);
        checks++;
        if (timed_out || got_data.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d outputs timeout=%0b required 4", got_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== req[i] || got_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_out[%0d]: data=%0d last=%b required %0d %b",
                             i, $signed(got_data[i]), got_last[i], $signed(req[i]), i == 3);
                end
            end
        end
        checks++;
        if (done_cyc != last_pop_cyc + 1) begin
            errors++;
            $display("FAIL basic_done_time: done at %0d last pop %0d required pop+1", done_cyc, last_pop_cyc);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b done=%b required 0 0", busy, done);
        end
        $display("test_basic done outputs=%0d", got_data.size());
    endtask

    task automatic test_multipass();
        logic [7:0] req [2];
`ifdef PSUM_DRAIN_RELU_EN
        req = '{8'd11, 8'd0};
`else
        req = '{8'd11, 8'hFC};
`endif
        beats = '{32'sd10, 32'sd20, 32'sd30, -32'sd40, 32'sd4, 32'sd4};
        do_start(2, 3, 2);
        run_job(70, 80, 0, 300);
        checks++;
        if (timed_out || got_data.size() != 2) begin
            errors++;
            $display("FAIL multipass_count: got %0d timeout=%0b required 2", got_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_data[i] !== req[i] || got_last[i] !== (i == 1)) begin
                    errors++;
                    $display("FAIL multipass_out[%0d]: data=%0d last=%b required %0d %b",
                             i, $signed(got_data[i]), got_last[i], $signed(req[i]), i == 1);
                end
            end
        end
        $display("test_multipass done outputs=%0d", got_data.size());
    endtask

    task automatic test_backpressure();
        int bi = 0;
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back(int'($urandom_range(200)) - 100);
        build_expected(4, 1, 0);
        do_start(4, 1, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            psum_valid = (bi < 4);
            psum_in    = beats[bi < 4 ? bi : 3];
            out_ready  = 1'b0;
            if (psum_valid && psum_ready) bi++;
        end
        checks++;
        if (bi != 2 || psum_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: accepted=%0d psum_ready=%b required 2 0", bi, psum_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data[0] || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%0d last=%b required 1 %0d 0",
                     out_valid, $signed(out_data), out_last, $signed(exp_data[0]));
        end
        void'(beats.pop_front());
        void'(beats.pop_front());
        run_job(100, 100, 0, 200);
        checks++;
        if (timed_out || got_data.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d timeout=%0b required 4", got_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                    errors++;
                    $display("FAIL bp_out[%0d]: data=%0d last=%b required %0d %b",
                             i, $signed(got_data[i]), got_last[i], $signed(exp_data[i]), exp_last[i]);
                end
            end
        end
        $display("test_backpressure done outputs=%0d", got_data.size());
    endtask

    task automatic test_wrap();
        logic [7:0] req;
`ifdef PSUM_DRAIN_RELU_EN
        req = 8'd0;
`else
        req = 8'hFF;
`endif
        beats = '{32'sh7FFFFFFF, 32'sd1};
        do_start(1, 2, 31);
        run_job(100, 100, 0, 100);
        checks++;
        if (timed_out || got_data.size() != 1 || got_data[0] !== req || got_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap: n=%0d data=%0d timeout=%0b required one output %0d last",
                     got_data.size(), got_data.size() > 0 ? $signed(got_data[0]) : 0, timed_out, $signed(req));
        end
        $display("test_wrap done");
    endtask

    task automatic test_cfg_clamp();
        beats.delete();
        beats.push_back(rand_psum());
        build_expected(1, 1, 0);
        do_start(0, 0, 0);
        do_start(5, 3, 4);
        run_job(100, 100, 0, 100);
        checks++;
        if (timed_out || n_done != 1 || got_data.size() != 1) begin
            errors++;
            $display("FAIL cfg_clamp_count: n=%0d done=%0d timeout=%0b required 1 1 0",
                     got_data.size(), n_done, timed_out);
        end else begin
            checks++;
            if (got_data[0] !== exp_data[0] || got_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL cfg_clamp_out: data=%0d last=%b required %0d 1",
                         $signed(got_data[0]), got_last[0], $signed(exp_data[0]));
            end
        end
        $display("test_cfg_clamp done");
    endtask

    task automatic test_back_to_back();
        int len, passes, shift, le, pe;
        for (int j = 0; j < 12; j++) begin
            len    = $urandom_range(20);
            passes = $urandom_range(3);
            shift  = ($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(8);
            le     = (len == 0) ? 1 : (len > 16 ? 16 : len);
            pe     = (passes == 0) ? 1 : passes;
            beats.delete();
            for (int i = 0; i < le * pe; i++) beats.push_back(rand_psum());
            build_expected(le, pe, shift);
            do_start(len, passes, shift);
            run_job($urandom_range(50, 100), $urandom_range(40, 100), 0, 300 + 30 * le * pe);
            checks++;
            if (timed_out || got_data.size() != exp_data.size()) begin
                errors++;
                $display("FAIL b2b_count job %0d: got %0d timeout=%0b required %0d",
                         j, got_data.size(), timed_out, exp_data.size());
            end else begin
                for (int i = 0; i < exp_data.size(); i++) begin
                    checks++;
                    if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                        errors++;
                        $display("FAIL b2b_out job %0d[%0d]: data=%0d last=%b required %0d %b",
                                 j, i, $signed(got_data[i]), got_last[i], $signed(exp_data[i]), exp_last[i]);
                    end
                end
            end
            $display("job %0d len=%0d passes=%0d shift=%0d outputs=%0d", j, le, pe, shift, got_data.size());
        end
    endtask

    task automatic test_reset_mid();
        beats.delete();
        for (int i = 0; i < 6; i++) beats.push_back(rand_psum());
        do_start(4, 3, 0);
        run_job(100, 100, 1, 100);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({psum_ready, out_valid, out_data, out_last, busy, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_async: outs=%b required all zero",
                     {psum_ready, out_valid, out_data, out_last, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        beats.delete();
        for (int i = 0; i < 8; i++) beats.push_back(rand_psum());
        build_expected(4, 2, 3);
        do_start(4, 2, 3);
        run_job(100, 100, 0, 200);
        checks++;
        if (timed_out || got_data.size() != 4) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d timeout=%0b required 4", got_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL reset_mid_out[%0d]: data=%0d required %0d",
                             i, $signed(got_data[i]), $signed(exp_data[i]));
                end
            end
        end
        $display("test_reset_mid done outputs=%0d", got_data.size());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_passes = '0; cfg_shift = '0;
        psum_in = '0; psum_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_multipass();
        test_backpressure();
        test_wrap();
        test_cfg_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_drain.md
# psum_drain

Downstream stage of a PE column: collects the 32-bit partial sums leaving the bottom PE and accumulates them in a local buffer across several input-channel passes. On the final pass it requantizes each accumulated value to an 8-bit activation and hands it to the activation writer through a 2-entry output FIFO with valid/ready handshake. It sits between the PE array's outPartialSum and the activation write-back path.

## Interface
- accumulationPar, 32, width of incoming partial sums and accumulator entries
- outPar, 8, width of requantized output (signed two's complement)
- DEPTH, 16, accumulator buffer entries (outputs per pass); power of two
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse; latches cfg_* and begins a job (ignored unless IDLE)
- cfg_len  input  $clog2(DEPTH)+1  entries per pass (0 treated as 1, values >DEPTH clamp to DEPTH)
- cfg_passes  input  8  passes per job (0 treated as 1)
- cfg_shift  input  5  arithmetic right shift applied before saturation
- psum_in  input  accumulationPar  partial sum from PE column (two's complement)
- psum_valid  input  1  psum_in valid
- psum_ready  output  1  block can accept psum_in
- out_data  output  outPar  requantized result
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_last  output  1  out_data is final entry of the job
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse after last output is popped from FIFO

## Operation
- FSM: IDLE -> (start) RUN -> (final beat accepted) DRAIN -> (FIFO empty) IDLE; done pulses on DRAIN->IDLE.
- Counters: entry pointer ptr (0..len-1), pass counter pc (0..passes-1). Beat accepted when psum_valid && psum_ready in RUN.
- On accepted beat: pc==0 -> buf[ptr] <= psum_in; else buf[ptr] <= buf[ptr] + psum_in (wraps modulo 2^accumulationPar, no saturation).
- ptr increments per beat; at len-1 it wraps to 0 and pc increments. After beat with ptr==len-1 and pc==passes-1, FSM enters DRAIN.
- Last pass (pc==passes-1, including passes==1): sum = (pc==0 ? psum_in : buf[ptr]+psum_in); result = sat(sum >>> cfg_shift) pushed to FIFO; buffer write optional (don't care).
- sat: clamp to [-2^(outPar-1), 2^(outPar-1)-1].
- psum_ready = (state==RUN) && (fifo_count<2). Non-last passes are also stalled by a full FIFO (deliberate; no combinational path from out_ready).
- out_last tagged on the FIFO entry from ptr==len-1 of last pass.
- start in RUN/DRAIN ignored; cfg_* sampled only at accepted start.

## Timing
- Reset: state IDLE, ptr=0, pc=0, FIFO empty; psum_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Buffer contents not reset (undefined until first-pass write).
- start at cycle t -> busy and psum_ready high at t+1.
- Latency: last-pass beat accepted at t -> out_valid at t+1 (registered FIFO head).
- Same-cycle FIFO push and pop with count==2: pop frees slot next cycle only; psum_ready from registered count.
- Out handshake: out_data/out_last held stable while out_valid && !out_ready.
- done: one cycle after final out pop; busy falls with done.
- Reset mid-job: immediate return to reset values; in-flight data discarded.

## Configuration
- PSUM_DRAIN_RELU_EN: defined -> negative sums clamp to 0 before shift/saturation (output range [0, 2^(outPar-1)-1]). Undefined -> signed saturation only.

## Test plan
- len=4, passes=1, shift=0, psums 5,-3,200,-200, out_ready=1 -> outputs 5,-3,127,-128; out_last on 4th; done one cycle after 4th pop.
- len=2, passes=3, shift=2, psums (10,20),(30,-40),(4,4) -> outputs 11,-4 (44>>>2, -16>>>2).
- Backpressure: len=4, passes=1, out_ready=0 -> psum_ready drops after 2 accepted beats; releasing out_ready drains all 4 in order, no loss/duplication.
- Wrap: passes=2, psums 0x7FFFFFFF then 1, shift=31 -> accumulator wraps to 0x80000000, output -1 (RELU_EN: 0).
- cfg_len=0, cfg_passes=0 -> behaves as single entry, single pass; start during busy ignored.
- rst_n asserted mid-pass 2 -> all outputs at reset values asynchronously; fresh job afterwards yields correct first-pass overwrite results.
